// File: rtl/rrf_commit_scheduler.sv
// In-order completion buffer that retires finished GPR writes to the ARF update ports in program order.
// Optional macro DUAL_COMMIT_EN enables a second commit per cycle on port B; without it only port A commits.
module rrf_commit_scheduler #(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_en_A,
  input  logic               alloc_en_B,
  input  logic [4:0]         alloc_addr_A,
  input  logic [4:0]         alloc_addr_B,
  output logic               alloc_ready,
  output logic [DEPTH_W-1:0] alloc_tag_A,
  output logic [DEPTH_W-1:0] alloc_tag_B,
  output logic               alloc_err,
  input  logic               wb_en_A,
  input  logic               wb_en_B,
  input  logic [DEPTH_W-1:0] wb_tag_A,
  input  logic [DEPTH_W-1:0] wb_tag_B,
  output logic               update_en_A,
  output logic [4:0]         update_addr_A,
  output logic               update_en_B,
  output logic [4:0]         update_addr_B,
  output logic [DEPTH_W:0]   count,
  output logic               empty
);

  localparam logic [DEPTH_W:0] READY_MAX = (DEPTH_W+1)'(DEPTH - 2);

  logic [DEPTH-1:0]   valid_q, valid_d, done_q, done_d;
  logic [4:0]         addr_q [DEPTH];
  logic [DEPTH_W-1:0] head_q, head_d, tail_q, tail_d, tag_a, tag_b;
  logic [DEPTH_W:0]   count_q, count_d, n_alloc, n_commit;
  logic               update_en_a_q, update_en_a_d, alloc_err_q, alloc_err_d;
  logic [4:0]         update_addr_a_q, update_addr_a_d;
  logic               do_alloc, c0, c1;

  assign tag_a       = tail_q;
  assign tag_b       = tail_q + DEPTH_W'(alloc_en_A);
  assign alloc_ready = (count_q <= READY_MAX);
  assign do_alloc    = alloc_ready & (alloc_en_A | alloc_en_B);
  assign n_alloc     = do_alloc ? ((DEPTH_W+1)'(alloc_en_A) + (DEPTH_W+1)'(alloc_en_B)) : '0;
  assign c0          = valid_q[head_q] & done_q[head_q];
  assign n_commit    = (DEPTH_W+1)'(c0) + (DEPTH_W+1)'(c1);

`ifdef DUAL_COMMIT_EN
  logic [DEPTH_W-1:0] head1;
  logic               update_en_b_q, update_en_b_d;
  logic [4:0]         update_addr_b_q, update_addr_b_d;

  // A same-destination pair must retire on separate cycles to keep ARF write order.
  assign head1 = head_q + DEPTH_W'(1);
  assign c1    = c0 & valid_q[head1] & done_q[head1] & (addr_q[head1] != addr_q[head_q]);

  always_comb begin
    update_en_b_d   = c1;
    update_addr_b_d = c1 ? addr_q[head1] : update_addr_b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_en_b_q   <= 1'b0;
      update_addr_b_q <= '0;
    end else begin
      update_en_b_q   <= update_en_b_d;
      update_addr_b_q <= update_addr_b_d;
    end
  end

  assign update_en_B   = update_en_b_q;
  assign update_addr_B = update_addr_b_q;
`else
  assign c1            = 1'b0;
  assign update_en_B   = 1'b0;
  assign update_addr_B = '0;
`endif

  // NOTE: every signal written here gets its default first, so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    // Writeback only counts against entries that were already live before this edge.
    if (wb_en_A && valid_q[wb_tag_A]) done_d[wb_tag_A] = 1'b1;
    if (wb_en_B && valid_q[wb_tag_B]) done_d[wb_tag_B] = 1'b1;
    if (c0) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (c1) begin
      valid_d[head_q + DEPTH_W'(1)] = 1'b0;
      done_d[head_q + DEPTH_W'(1)]  = 1'b0;
    end
    if (do_alloc && alloc_en_A) begin
      valid_d[tag_a] = 1'b1;
      done_d[tag_a]  = 1'b0;
    end
    if (do_alloc && alloc_en_B) begin
      valid_d[tag_b] = 1'b1;
      done_d[tag_b]  = 1'b0;
    end
    head_d          = head_q + n_commit[DEPTH_W-1:0];
    tail_d          = tail_q + n_alloc[DEPTH_W-1:0];
    count_d         = count_q + n_alloc - n_commit;
    alloc_err_d     = (alloc_en_A | alloc_en_B) & ~alloc_ready;
    update_en_a_d   = c0;
    update_addr_a_d = c0 ? addr_q[head_q] : update_addr_a_q;
  end

  // NOTE: state flops use non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q         <= '0;
      done_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      alloc_err_q     <= 1'b0;
      update_en_a_q   <= 1'b0;
      update_addr_a_q <= '0;
    end else begin
      valid_q         <= valid_d;
      done_q          <= done_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      alloc_err_q     <= alloc_err_d;
      update_en_a_q   <= update_en_a_d;
      update_addr_a_q <= update_addr_a_d;
    end
  end

  // NOTE: the address payload is not reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    if (do_alloc && alloc_en_A) addr_q[tag_a] <= alloc_addr_A;
    if (do_alloc && alloc_en_B) addr_q[tag_b] <= alloc_addr_B;
  end

  assign alloc_tag_A   = tag_a;
  assign alloc_tag_B   = tag_b;
  assign alloc_err     = alloc_err_q;
  assign update_en_A   = update_en_a_q;
  assign update_addr_A = update_addr_a_q;
  assign count         = count_q;
  assign empty         = (count_q == '0);

endmodule

// File: tb/tb_rrf_commit_scheduler.sv
// Directed bench for rrf_commit_scheduler; expectations follow the DUAL_COMMIT_EN setting of the build.
module tb_rrf_commit_scheduler;
  localparam int DEPTH_W = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               alloc_en_A, alloc_en_B, wb_en_A, wb_en_B;
  logic [4:0]         alloc_addr_A, alloc_addr_B;
  logic [DEPTH_W-1:0] wb_tag_A, wb_tag_B, alloc_tag_A, alloc_tag_B;
  logic               alloc_ready, alloc_err, update_en_A, update_en_B, empty;
  logic [4:0]         update_addr_A, update_addr_B;
  logic [DEPTH_W:0]   count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rrf_commit_scheduler dut (
    .clk(clk), .rst(rst),
    .alloc_en_A(alloc_en_A), .alloc_en_B(alloc_en_B),
    .alloc_addr_A(alloc_addr_A), .alloc_addr_B(alloc_addr_B),
    .alloc_ready(alloc_ready), .alloc_tag_A(alloc_tag_A), .alloc_tag_B(alloc_tag_B),
    .alloc_err(alloc_err),
    .wb_en_A(wb_en_A), .wb_en_B(wb_en_B), .wb_tag_A(wb_tag_A), .wb_tag_B(wb_tag_B),
    .update_en_A(update_en_A), .update_addr_A(update_addr_A),
    .update_en_B(update_en_B), .update_addr_B(update_addr_B),
    .count(count), .empty(empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_en_A = 1'b0; alloc_en_B = 1'b0; alloc_addr_A = '0; alloc_addr_B = '0;
    wb_en_A = 1'b0; wb_en_B = 1'b0; wb_tag_A = '0; wb_tag_B = '0;
  endtask

  // Alloc r5/r6 at tags 0/1, finish tag 1 then tag 0, watch both retire in order.
  task automatic pair_test(input string nm);
    alloc_en_A = 1'b1; alloc_addr_A = 5'd5; alloc_en_B = 1'b1; alloc_addr_B = 5'd6;
    #1;
    chk({nm, "_tagA"}, 32'(alloc_tag_A), 0);
    chk({nm, "_tagB"}, 32'(alloc_tag_B), 1);
    tick(); idle();
    chk({nm, "_count2"}, 32'(count), 2);
    wb_en_A = 1'b1; wb_tag_A = 3'd1;
    tick(); idle();
    chk({nm, "_nocommit1"}, 32'(update_en_A), 0);
    wb_en_A = 1'b1; wb_tag_A = 3'd0;
    tick(); idle();
    chk({nm, "_nocommit0"}, 32'(update_en_A), 0);
    tick();
`ifdef DUAL_COMMIT_EN
    chk({nm, "_enA"}, 32'(update_en_A), 1);
    chk({nm, "_addrA"}, 32'(update_addr_A), 5);
    chk({nm, "_enB"}, 32'(update_en_B), 1);
    chk({nm, "_addrB"}, 32'(update_addr_B), 6);
    chk({nm, "_count0"}, 32'(count), 0);
    tick();
    chk({nm, "_holdA"}, 32'(update_addr_A), 5);
`else
    chk({nm, "_enA_1st"}, 32'(update_en_A), 1);
    chk({nm, "_addrA_1st"}, 32'(update_addr_A), 5);
    chk({nm, "_enB_1st"}, 32'(update_en_B), 0);
    chk({nm, "_count1"}, 32'(count), 1);
    tick();
    chk({nm, "_enA_2nd"}, 32'(update_en_A), 1);
    chk({nm, "_addrA_2nd"}, 32'(update_addr_A), 6);
    chk({nm, "_enB_2nd"}, 32'(update_en_B), 0);
    chk({nm, "_addrB_tied"}, 32'(update_addr_B), 0);
    chk({nm, "_count0"}, 32'(count), 0);
    tick();
    chk({nm, "_holdA"}, 32'(update_addr_A), 6);
`endif
    chk({nm, "_idleA"}, 32'(update_en_A), 0);
    chk({nm, "_empty"}, 32'(empty), 1);
  endtask

  initial begin
    // Reset and idle
    idle(); rst = 1'b1;
    tick(); tick();
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_enA", 32'(update_en_A), 0);
    chk("rst_enB", 32'(update_en_B), 0);
    chk("rst_err", 32'(alloc_err), 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("idle_count", 32'(count), 0);
    chk("idle_enA", 32'(update_en_A), 0);
    chk("idle_ready", 32'(alloc_ready), 1);

    pair_test("pair");

    // Fill all entries starting at tag 2; entry t carries r(16+t)
    for (int i = 0; i < 4; i++) begin
      alloc_en_A = 1'b1; alloc_addr_A = 5'(16 + ((2 + 2*i) % 8));
      alloc_en_B = 1'b1; alloc_addr_B = 5'(16 + ((3 + 2*i) % 8));
      tick();
      chk("fill_count", 32'(count), 32'(2*(i+1)));
    end
    idle();
    chk("full_ready", 32'(alloc_ready), 0);
    chk("full_empty", 32'(empty), 0);
    alloc_en_A = 1'b1; alloc_en_B = 1'b1; alloc_addr_A = 5'd31; alloc_addr_B = 5'd31;
    tick(); idle();
    chk("drop_err", 32'(alloc_err), 1);
    chk("drop_count", 32'(count), 8);
    tick();
    chk("drop_err_clear", 32'(alloc_err), 0);
`ifdef DUAL_COMMIT_EN
    for (int j = 0; j <= 4; j++) begin
      if (j < 4) begin
        wb_en_A = 1'b1; wb_tag_A = 3'((2 + 2*j) % 8);
        wb_en_B = 1'b1; wb_tag_B = 3'((3 + 2*j) % 8);
      end else idle();
      tick();
      if (j >= 1) begin
        chk("drain_enA", 32'(update_en_A), 1);
        chk("drain_addrA", 32'(update_addr_A), 32'(16 + ((2*j) % 8)));
        chk("drain_enB", 32'(update_en_B), 1);
        chk("drain_addrB", 32'(update_addr_B), 32'(16 + ((2*j + 1) % 8)));
        chk("drain_count", 32'(count), 32'(8 - 2*j));
        chk("drain_ready", 32'(alloc_ready), 32'((8 - 2*j) <= 6));
      end else chk("drain_first", 32'(update_en_A), 0);
    end
`else
    for (int j = 0; j <= 8; j++) begin
      if (j < 4) begin
        wb_en_A = 1'b1; wb_tag_A = 3'((2 + 2*j) % 8);
        wb_en_B = 1'b1; wb_tag_B = 3'((3 + 2*j) % 8);
      end else idle();
      tick();
      if (j >= 1) begin
        chk("drain_enA", 32'(update_en_A), 1);
        chk("drain_addrA", 32'(update_addr_A), 32'(16 + ((1 + j) % 8)));
        chk("drain_enB", 32'(update_en_B), 0);
        chk("drain_count", 32'(count), 32'(8 - j));
        chk("drain_ready", 32'(alloc_ready), 32'((8 - j) <= 6));
      end else chk("drain_first", 32'(update_en_A), 0);
    end
`endif
    tick();
    chk("drained_empty", 32'(empty), 1);
    chk("drained_enA", 32'(update_en_A), 0);
    chk("wrap_tail", 32'(alloc_tag_A), 2);

    // Same destination r3 at head and head+1
    alloc_en_A = 1'b1; alloc_addr_A = 5'd3; alloc_en_B = 1'b1; alloc_addr_B = 5'd3;
    tick(); idle();
    wb_en_A = 1'b1; wb_tag_A = 3'd2; wb_en_B = 1'b1; wb_tag_B = 3'd3;
    tick(); idle();
    tick();
    chk("samedst_k_enA", 32'(update_en_A), 1);
    chk("samedst_k_addrA", 32'(update_addr_A), 3);
    chk("samedst_k_enB", 32'(update_en_B), 0);
    chk("samedst_k_count", 32'(count), 1);
    tick();
    chk("samedst_k1_enA", 32'(update_en_A), 1);
    chk("samedst_k1_addrA", 32'(update_addr_A), 3);
    chk("samedst_k1_enB", 32'(update_en_B), 0);
    chk("samedst_k1_count", 32'(count), 0);

    // Writebacks to an unallocated tag 4, also on the edge that allocates it
    wb_en_A = 1'b1; wb_tag_A = 3'd4;
    tick(); idle();
    chk("ghost_wb_count", 32'(count), 0);
    chk("ghost_wb_empty", 32'(empty), 1);
    alloc_en_A = 1'b1; alloc_addr_A = 5'd7; wb_en_A = 1'b1; wb_tag_A = 3'd4;
    #1;
    chk("alloc_tag4", 32'(alloc_tag_A), 4);
    tick(); idle();
    alloc_en_B = 1'b1; alloc_addr_B = 5'd8;
    #1;
    chk("b_alone_tag", 32'(alloc_tag_B), 5);
    tick(); idle();
    wb_en_A = 1'b1; wb_tag_A = 3'd5; wb_en_B = 1'b1; wb_tag_B = 3'd5;
    tick(); idle();
    repeat (3) tick();
    chk("blocked_enA", 32'(update_en_A), 0);
    chk("blocked_count", 32'(count), 2);
    wb_en_B = 1'b1; wb_tag_B = 3'd4;
    tick(); idle();
    tick();
    chk("unblock_enA", 32'(update_en_A), 1);
    chk("unblock_addrA", 32'(update_addr_A), 7);
`ifdef DUAL_COMMIT_EN
    chk("unblock_addrB", 32'(update_addr_B), 8);
    chk("unblock_count", 32'(count), 0);
`else
    chk("unblock_count", 32'(count), 1);
    tick();
    chk("unblock2_addrA", 32'(update_addr_A), 8);
    chk("unblock2_count", 32'(count), 0);
`endif

    // Asynchronous reset while commits are in flight with five entries live
    alloc_en_A = 1'b1; alloc_addr_A = 5'd20; alloc_en_B = 1'b1; alloc_addr_B = 5'd21;
    tick();
    alloc_addr_A = 5'd22; alloc_addr_B = 5'd23;
    tick();
    alloc_en_B = 1'b0; alloc_addr_A = 5'd24;
    tick(); idle();
    chk("pre_rst_count", 32'(count), 5);
    wb_en_A = 1'b1; wb_tag_A = 3'd6; wb_en_B = 1'b1; wb_tag_B = 3'd7;
    tick(); idle();
    tick();
    chk("pre_rst_enA", 32'(update_en_A), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_enA", 32'(update_en_A), 0);
    chk("async_enB", 32'(update_en_B), 0);
    chk("async_addrA", 32'(update_addr_A), 0);
    chk("async_count", 32'(count), 0);
    chk("async_empty", 32'(empty), 1);
    chk("async_ready", 32'(alloc_ready), 1);
    #1 rst = 1'b0;

    pair_test("post_rst_pair");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
